// File: rtl/dff_bank_arbiter.sv
// rtl/dff_bank_arbiter.sv - round-robin arbiter and write sequencer for a shared data register
// Optional feature macro: DFF_ARB_LOCK_EN (adds a lock input for back-to-back writes)
module dff_bank_arbiter #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8,
  parameter int IDW   = 2
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] wdata,
`ifdef DFF_ARB_LOCK_EN
  input  logic                  lock,
`endif
  output logic [NREQ-1:0]       gnt,
  output logic [IDW-1:0]        grant_id,
  output logic                  busy,
  output logic [WIDTH-1:0]      data_out,
  output logic                  data_valid,
  output logic [15:0]           write_count
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [IDW-1:0]   ptr_q, ptr_d;
  logic [NREQ-1:0]  gnt_q, gnt_d;
  logic [IDW-1:0]   grant_id_q, grant_id_d;
  logic             busy_q, busy_d;
  logic [WIDTH-1:0] data_out_q, data_out_d;
  logic             data_valid_q, data_valid_d;
  logic [15:0]      write_count_q, write_count_d;

  logic             found;
  logic [IDW-1:0]   sel_id;
  logic             hold;
  logic             lock_hold;
  logic [WIDTH-1:0] wslice;
  logic [IDW-1:0]   ptr_next;

  // The granted requester must still be asserting at the GRANT edge for the write to happen
  assign hold   = req[grant_id_q];
  assign wslice = wdata[int'(grant_id_q)*WIDTH +: WIDTH];

  // Pointer moves one past the last winner so it becomes lowest priority next round
  assign ptr_next = (int'(grant_id_q) == NREQ-1) ? '0 : grant_id_q + 1'b1;

`ifdef DFF_ARB_LOCK_EN
  assign lock_hold = lock & hold;
`else
  assign lock_hold = 1'b0;
`endif

  // Round-robin search: first asserted request starting at ptr, wrapping modulo NREQ
  always_comb begin
    int idx;
    found  = 1'b0;
    sel_id = '0;
    idx    = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(ptr_q) + k) % NREQ;
      if (!found && req[idx]) begin
        found  = 1'b1;
        sel_id = idx[IDW-1:0];
      end
    end
  end

  // Next-state and registered-output computation for the IDLE/GRANT sequencer
  always_comb begin
    state_d       = state_q;
    ptr_d         = ptr_q;
    gnt_d         = gnt_q;
    grant_id_d    = grant_id_q;
    busy_d        = busy_q;
    data_out_d    = data_out_q;
    data_valid_d  = 1'b0;
    write_count_d = write_count_q;
    case (state_q)
      IDLE: begin
        if (found) begin
          gnt_d      = NREQ'(1) << sel_id;
          grant_id_d = sel_id;
          busy_d     = 1'b1;
          state_d    = GRANT;
        end
      end
      GRANT: begin
        if (hold) begin
          data_out_d    = wslice;
          data_valid_d  = 1'b1;
          write_count_d = write_count_q + 16'd1;
        end
        if (!lock_hold) begin
          ptr_d      = ptr_next;
          gnt_d      = '0;
          grant_id_d = '0;
          busy_d     = 1'b0;
          state_d    = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers; reset clears everything, including an in-flight write
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      ptr_q         <= '0;
      gnt_q         <= '0;
      grant_id_q    <= '0;
      busy_q        <= 1'b0;
      data_out_q    <= '0;
      data_valid_q  <= 1'b0;
      write_count_q <= '0;
    end else begin
      state_q       <= state_d;
      ptr_q         <= ptr_d;
      gnt_q         <= gnt_d;
      grant_id_q    <= grant_id_d;
      busy_q        <= busy_d;
      data_out_q    <= data_out_d;
      data_valid_q  <= data_valid_d;
      write_count_q <= write_count_d;
    end
  end

  assign gnt         = gnt_q;
  assign grant_id    = grant_id_q;
  assign busy        = busy_q;
  assign data_out    = data_out_q;
  assign data_valid  = data_valid_q;
  assign write_count = write_count_q;

endmodule

// File: tb/tb_dff_bank_arbiter.sv
// tb/tb_dff_bank_arbiter.sv - self-checking bench for dff_bank_arbiter
module tb_dff_bank_arbiter;
  localparam int NREQ  = 4;
  localparam int WIDTH = 8;
  localparam int IDW   = 2;

  logic                  clock;
  logic                  reset_n;
  logic [NREQ-1:0]       req;
  logic [NREQ*WIDTH-1:0] wdata;
  logic                  lock;
  logic [NREQ-1:0]       gnt;
  logic [IDW-1:0]        grant_id;
  logic                  busy;
  logic [WIDTH-1:0]      data_out;
  logic                  data_valid;
  logic [15:0]           write_count;

  dff_bank_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .IDW(IDW)) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .req         (req),
    .wdata       (wdata),
`ifdef DFF_ARB_LOCK_EN
    .lock        (lock),
`endif
    .gnt         (gnt),
    .grant_id    (grant_id),
    .busy        (busy),
    .data_out    (data_out),
    .data_valid  (data_valid),
    .write_count (write_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: which requester (if any) currently holds the grant
  int          m_cur;
  int          m_ptr;
  logic [7:0]  m_dout;
  logic        m_dv;
  int          m_cnt;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_cur  = -1;
    m_ptr  = 0;
    m_dout = 8'h00;
    m_dv   = 1'b0;
    m_cnt  = 0;
  endtask

  task automatic model_edge();
    bit keep;
    if (m_cur < 0) begin
      m_dv = 1'b0;
      for (int k = 0; k < NREQ; k++) begin
        int i;
        i = (m_ptr + k) % NREQ;
        if (m_cur < 0 && req[i]) m_cur = i;
      end
    end else begin
      keep = 1'b0;
      if (req[m_cur]) begin
        m_dout = wdata[m_cur*WIDTH +: WIDTH];
        m_dv   = 1'b1;
        m_cnt  = (m_cnt + 1) % 65536;
`ifdef DFF_ARB_LOCK_EN
        keep = lock;
`endif
      end else begin
        m_dv = 1'b0;
      end
      if (!keep) begin
        m_ptr = (m_cur + 1) % NREQ;
        m_cur = -1;
      end
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".gnt"},   32'(gnt),        (m_cur < 0) ? 32'd0 : (32'd1 << m_cur));
    check({tag, ".id"},    32'(grant_id),   (m_cur < 0) ? 32'd0 : 32'(m_cur));
    check({tag, ".busy"},  32'(busy),       32'(m_cur >= 0));
    check({tag, ".dout"},  32'(data_out),   32'(m_dout));
    check({tag, ".dv"},    32'(data_valid), 32'(m_dv));
    check({tag, ".count"}, 32'(write_count), 32'(m_cnt));
  endtask

  task automatic step(input logic [3:0] r, input logic [31:0] w, input string tag);
    req   = r;
    wdata = w;
    @(posedge clock);
    model_edge();
    #1;
    check_all(tag);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    model_reset();
    @(posedge clock);
    #1;
    reset_n = 1'b1;
  endtask

  logic [15:0] saved_cnt;

  initial begin
    reset_n = 1'b0;
    req     = '0;
    wdata   = '0;
    lock    = 1'b0;
    model_reset();
    @(posedge clock);
    @(posedge clock);
    #1;
    check("reset.gnt",   32'(gnt),         32'd0);
    check("reset.dout",  32'(data_out),    32'd0);
    check("reset.count", 32'(write_count), 32'd0);
    check("reset.busy",  32'(busy),        32'd0);
    reset_n = 1'b1;

    // Single write from requester 2
    step(4'b0100, 32'h00A5_0000, "single.e1");
    check("single.gnt", 32'(gnt), 32'h4);
    check("single.id",  32'(grant_id), 32'd2);
    step(4'b0100, 32'h00A5_0000, "single.e2");
    check("single.dout",  32'(data_out), 32'hA5);
    check("single.dv",    32'(data_valid), 32'd1);
    check("single.count", 32'(write_count), 32'd1);
    step(4'b0000, 32'h0, "single.e3");
    check("single.dv_drop", 32'(data_valid), 32'd0);

    // Asynchronous reset in the middle of a GRANT
    step(4'b1111, 32'h0, "rst.grant");
    #2;
    reset_n = 1'b0;
    #1;
    check("rst.async.gnt",   32'(gnt), 32'd0);
    check("rst.async.dout",  32'(data_out), 32'd0);
    check("rst.async.count", 32'(write_count), 32'd0);
    model_reset();
    @(posedge clock);
    #1;
    reset_n = 1'b1;

    // Round robin with everyone requesting
    for (int i = 0; i < 10; i++) begin
      step(4'b1111, 32'h1312_1110, "rr");
      if (i % 2 == 0) check("rr.gnt_seq", 32'(gnt), 32'd1 << ((i / 2) % 4));
      else            check("rr.dout_seq", 32'(data_out), 32'h10 + 32'((i / 2) % 4));
    end

    // Withdrawal: requester 1 granted, then drops before the write edge
    step(4'b0010, 32'h1312_1110, "wd.grant");
    check("wd.gnt", 32'(gnt), 32'h2);
    saved_cnt = write_count;
    step(4'b0000, 32'h1312_1199, "wd.drop");
    check("wd.dout",  32'(data_out), 32'h10);
    check("wd.dv",    32'(data_valid), 32'd0);
    check("wd.count", 32'(write_count), 32'(saved_cnt));
    step(4'b0110, 32'h1312_1110, "wd.next");
    check("wd.next_gnt", 32'(gnt), 32'h4);
    step(4'b0110, 32'h1312_1110, "wd.write");

    // Counter wrap: preload near the top, then two more writes
    force dut.write_count_q = 16'hFFFE;
    #1;
    release dut.write_count_q;
    m_cnt = 16'hFFFE;
    step(4'b0001, 32'h0000_00C3, "wrap.g1");
    step(4'b0001, 32'h0000_00C3, "wrap.w1");
    check("wrap.ffff", 32'(write_count), 32'hFFFF);
    step(4'b0001, 32'h0000_00C4, "wrap.g2");
    step(4'b0001, 32'h0000_00C4, "wrap.w2");
    check("wrap.zero", 32'(write_count), 32'h0);
    check("wrap.dv",   32'(data_valid), 32'd1);

`ifdef DFF_ARB_LOCK_EN
    // Locked grant: three back-to-back writes, then release to requester 3
    do_reset();
    lock = 1'b1;
    step(4'b1001, 32'h0000_0001, "lock.grant");
    for (int v = 1; v <= 3; v++) begin
      step(4'b1001, 32'(v), "lock.burst");
      check("lock.gnt",  32'(gnt), 32'h1);
      check("lock.dout", 32'(data_out), 32'(v));
      check("lock.dv",   32'(data_valid), 32'd1);
    end
    lock = 1'b0;
    step(4'b1001, 32'h0000_0003, "lock.release");
    step(4'b1001, 32'h0000_0003, "lock.next");
    check("lock.next_gnt", 32'(gnt), 32'h8);
`endif

    // Randomized traffic against the reference model
    for (int n = 0; n < 3000; n++) begin
      logic [3:0] r;
      r = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) r = 4'b0000;
`ifdef DFF_ARB_LOCK_EN
      lock = ($urandom_range(0, 2) == 0);
`endif
      step(r, $urandom, "rand");
      if ($urandom_range(0, 499) == 0) do_reset();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/dff_bank_arbiter.md
Name: dff_bank_arbiter

Overview:
- Round-robin arbiter and write sequencer for a shared WIDTH-bit D flip-flop data register.
- Up to NREQ requesters compete for write access. One winner is granted per arbitration, its data is captured into the register, and the result is held on data_out.
- Sits between requester logic and the shared storage flops. It is the only writer of that register.

Parameters:
- NREQ, 4, number of requesters (2..8)
- WIDTH, 8, data register width in bits
- IDW, 2, width of grant_id; must satisfy 2**IDW >= NREQ

Ports:
- clock  input  1  rising-edge clock
- reset_n  input  1  asynchronous active-low reset
- req  input  NREQ  per-requester write request, level-sensitive
- wdata  input  NREQ*WIDTH  flattened write data; requester i occupies bits [i*WIDTH +: WIDTH]
- gnt  output  NREQ  one-hot grant, registered
- grant_id  output  IDW  binary index of the current grant; 0 when no grant
- busy  output  1  high while in the GRANT state
- data_out  output  WIDTH  shared register contents
- data_valid  output  1  one-cycle pulse after each completed write
- write_count  output  16  completed-write counter, wraps 0xFFFF->0

Behaviour:
- Reset (asynchronous assert, synchronous deassert):
  - gnt=0, grant_id=0, busy=0, data_out=0, data_valid=0, write_count=0.
  - Round-robin pointer ptr=0; state=IDLE.
- State machine: IDLE, GRANT.
- IDLE:
  - At each rising edge, if req!=0, select the first set bit searching ptr, ptr+1, ..., wrapping modulo NREQ.
  - Set gnt to that one-hot value, grant_id to its index, busy=1; go to GRANT.
  - If req==0, stay in IDLE; outputs unchanged except data_valid=0.
- GRANT (exactly one cycle):
  - At the next edge, if req[grant_id] is still high: data_out <= wdata slice of grant_id; data_valid=1 for one cycle; write_count++.
  - If req[grant_id] has dropped (withdrawn): no write; data_out unchanged; data_valid=0.
  - In both cases: ptr <= (grant_id+1) mod NREQ, gnt=0, grant_id=0, busy=0, return to IDLE.
- Throughput: at most one write per 2 cycles. Request-to-data_out latency is 2 edges.
- Other requests during GRANT are ignored until the next IDLE edge. No request is latched; req must still be high when sampled.
- Fairness: while a requester holds req continuously, at most NREQ-1 other grants occur before it is granted.
- Reset mid-GRANT: all outputs clear immediately and the write is lost; ptr=0.

Optional Feature:
- Macro: DFF_ARB_LOCK_EN.
- When defined:
  - Adds input lock (1 bit).
  - In GRANT, if lock=1 and req[grant_id]=1 at the edge: perform the write, stay in GRANT with the same grant, ptr unchanged.
  - This gives back-to-back writes, one per cycle, with data_valid held high.
  - The grant releases on the first edge with lock=0 or req[grant_id]=0. Then ptr advances as in the normal GRANT exit.
- When undefined: the lock port does not exist and GRANT always lasts one cycle.

Test Plan (NREQ=4, WIDTH=8):
- Reset: drive reset_n=0 mid-simulation with req=4'b1111 -> gnt=0, data_out=8'h00, write_count=0 immediately, without waiting for a clock edge.
- Single write: req=4'b0100, wdata[2]=8'hA5 held -> edge1: gnt=4'b0100, grant_id=2; edge2: data_out=8'hA5, data_valid=1 for one cycle, write_count=1.
- Round-robin: req=4'b1111 held, wdata[i]=8'h10+i -> grants cycle 0001,0010,0100,1000,0001 on alternate cycles; data_out sequence 10,11,12,13,10.
- Withdrawal: grant on requester 1, then drop req[1] before the GRANT edge -> data_out unchanged, data_valid=0, write_count unchanged, next grant goes to requester 2 when req=4'b0110.
- Counter wrap: force 65535 writes, then one more -> write_count=0x0000 and data_valid still pulses.
- Lock (DFF_ARB_LOCK_EN): lock=1, req=4'b1001, wdata[0] stepping 1,2,3 per cycle -> three consecutive writes of 1,2,3 with gnt=0001 throughout; lock=0 -> release, next grant gnt=1000.
